trasmettitore_seriale: RTL and testbench
========================================

TRASMETTITORE_SERIALE -- requirements
Module: trasmettitore_seriale

Interface
REQ-001 The block SHALL have parameter BIT_TICKS, default 16, giving the number of clock periods per serial bit time.
REQ-002 The block SHALL have parameter PARITY, default 0, selecting 0 = no parity bit, 1 = even parity, 2 = odd parity.
REQ-003 The block SHALL have port clock, input, 1 bit: the single system clock; all state changes occur on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port dav_, input, 1 bit: active-low data-valid from the producer.
REQ-006 The block SHALL have port byte, input, 8 bits: the data to transmit, stable while dav_=0.
REQ-007 The block SHALL have port rfd, output, 1 bit: active-high ready-for-data to the producer.
REQ-008 The block SHALL have port txd, output, 1 bit: the serial line, idle high.

Function
REQ-009 Frame SHALL be: start bit 0; data bits byte[0] first through byte[7]; parity bit if PARITY!=0; one stop bit 1.
REQ-010 Each frame bit SHALL hold txd constant for exactly BIT_TICKS clock periods.
REQ-011 Parity bit SHALL make the count of 1s over data plus parity even (PARITY=1) or odd (PARITY=2).
REQ-012 States SHALL be IDLE, START, DATA, PAR, STOP and WDAV.
REQ-013 IDLE SHALL drive rfd=1 and txd=1.
REQ-014 In IDLE, a rising edge sampling dav_=0 (edge E0) SHALL capture byte into an internal buffer, compute parity, set rfd=0 and txd=0, and enter START.
REQ-015 Start bit SHALL occupy edges E0..E(BIT_TICKS); data bit i SHALL be driven at E(BIT_TICKS*(i+1)).
REQ-016 A down-counter SHALL time each bit, reloaded with BIT_TICKS-1 at every bit boundary.
REQ-017 A bit counter SHALL count data bits from 8 down to 1 and SHALL NOT wrap; after bit 7 expires, the state SHALL advance to PAR if PARITY!=0, else to STOP.
REQ-018 When the stop bit expires, the state SHALL advance to WDAV with txd=1 and rfd=0.
REQ-019 In WDAV, sampling dav_=1 SHALL set rfd=1 and enter IDLE; while dav_=0 the state SHALL remain WDAV, and no second frame SHALL be sent for the same handshake.
REQ-020 byte and dav_ changes during START, DATA, PAR or STOP SHALL NOT affect the frame in progress.
REQ-021 txd SHALL be driven from a register and SHALL be glitch-free.
REQ-022 Minimum frame-to-frame spacing SHALL be (10 + (PARITY!=0)) * BIT_TICKS + 2 clocks from E0 to the next capture edge.

Reset
REQ-023 While reset=1, the block SHALL immediately force state=IDLE, txd=1, rfd=1, and clear the counters and buffer to 0, independent of clock.
REQ-024 Reset asserted mid-frame SHALL abort the frame with no completion; txd SHALL return to 1 at once.
REQ-025 On the first rising edge after reset deasserts with dav_=0 already low, the block SHALL treat it as a new capture (E0).
REQ-026 Reset values SHALL be: txd=1, rfd=1.

Verification
REQ-027 Scenario, default parameters: byte=8'hA5 with dav_=0 in IDLE -> txd sequence 0,1,0,1,0,0,1,0,1,1, each bit lasting 16 clocks; rfd=0 from E0, and rfd=1 one edge after dav_=1 is seen in WDAV.
REQ-028 Scenario, PARITY=1: byte=8'h07 -> data bits 1,1,1,0,0,0,0,0, then parity 1, then stop 1; frame length 176 clocks.
REQ-029 Scenario, PARITY=2: byte=8'h00 -> parity bit 1; with byte=8'hFF -> parity bit 1.
REQ-030 Scenario: dav_ held 0 for 400 clocks with byte=8'h3C -> exactly one frame is sent, the block stays in WDAV with txd=1, and rfd=1 follows within 1 clock after dav_=1.
REQ-031 Scenario: reset pulsed at clock 50 of a frame for byte=8'hFF -> txd=1 and rfd=1 within the pulse, and no further low bits appear.
REQ-032 Scenario: byte changes from 8'h55 to 8'hAA one clock after capture -> the line carries 8'h55.
REQ-033 Scenario: the output is looped back into the existing serial receiver -> received byte matches the sent byte for 8'h00, 8'hFF and 8'h5A, and the receiver's dav_ goes low once per frame.

Source files
------------

// File: rtl/trasmettitore_seriale.sv
// trasmettitore_seriale: byte-wide to asynchronous-serial transmitter with a
// dav_/rfd handshake toward the producer.
//
// Frame: start bit 0, data bits LSB first, optional parity bit, one stop bit 1.
// Each frame bit lasts BIT_TICKS clock periods. After the stop bit the block
// waits for dav_ to return high, so each handshake sends exactly one frame.
//
// Parameters
//   BIT_TICKS : clock periods per serial bit time
//   PARITY    : 0 = none, 1 = even, 2 = odd
// Ports
//   clock   : system clock, rising edge active
//   reset   : asynchronous, active-high reset
//   dav_    : active-low data valid from the producer
//   byte_in : data to transmit, stable while dav_ = 0
//             (`byte` is a reserved word, so the port carries a suffix)
//   rfd     : active-high ready-for-data to the producer
//   txd     : serial line, idle high, driven straight from a flop
module trasmettitore_seriale #(
  parameter int BIT_TICKS = 16,
  parameter int PARITY    = 0
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       dav_,
  input  logic [7:0] byte_in,
  output logic       rfd,
  output logic       txd
);

  localparam int TW = (BIT_TICKS > 1) ? $clog2(BIT_TICKS) : 1;
  localparam logic [TW-1:0] TICK_RELOAD = TW'(BIT_TICKS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PAR,
    STOP,
    WDAV
  } state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [3:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    buf_q, buf_d;
  logic          par_q, par_d;
  logic          txd_q, txd_d;
  logic          rfd_q, rfd_d;
  logic          tick_zero;

  assign tick_zero = (tick_q == '0);
  assign txd       = txd_q;
  assign rfd       = rfd_q;

  // State and datapath registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      tick_q    <= '0;
      bit_cnt_q <= '0;
      buf_q     <= '0;
      par_q     <= 1'b0;
      txd_q     <= 1'b1;
      rfd_q     <= 1'b1;
    end else begin
      state_q   <= state_d;
      tick_q    <= tick_d;
      bit_cnt_q <= bit_cnt_d;
      buf_q     <= buf_d;
      par_q     <= par_d;
      txd_q     <= txd_d;
      rfd_q     <= rfd_d;
    end
  end

  // Next state, bit timing and capture
  always_comb begin
    state_d   = state_q;
    tick_d    = tick_q;
    bit_cnt_d = bit_cnt_q;
    buf_d     = buf_q;
    par_d     = par_q;
    unique case (state_q)
      IDLE: begin
        if (!dav_) begin
          state_d   = START;
          tick_d    = TICK_RELOAD;
          bit_cnt_d = 4'd8;
          buf_d     = byte_in;
          par_d     = (PARITY == 2) ? ~(^byte_in) : (^byte_in);
        end
      end
      START: begin
        if (tick_zero) begin
          state_d = DATA;
          tick_d  = TICK_RELOAD;
        end else begin
          tick_d = tick_q - TW'(1);
        end
      end
      DATA: begin
        // bit_cnt runs 8..1 while bits 0..7 are on the line; it parks at 1
        if (tick_zero) begin
          tick_d = TICK_RELOAD;
          if (bit_cnt_q == 4'd1) begin
            state_d = (PARITY != 0) ? PAR : STOP;
          end else begin
            bit_cnt_d = bit_cnt_q - 4'd1;
          end
        end else begin
          tick_d = tick_q - TW'(1);
        end
      end
      PAR: begin
        if (tick_zero) begin
          state_d = STOP;
          tick_d  = TICK_RELOAD;
        end else begin
          tick_d = tick_q - TW'(1);
        end
      end
      STOP: begin
        if (tick_zero) begin
          state_d = WDAV;
        end else begin
          tick_d = tick_q - TW'(1);
        end
      end
      WDAV: begin
        if (dav_) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Registered outputs: the line level is chosen for the bit being entered,
  // so txd changes only on bit boundaries.
  always_comb begin
    txd_d = txd_q;
    rfd_d = rfd_q;
    unique case (state_q)
      IDLE: begin
        txd_d = dav_;
        rfd_d = dav_;
      end
      WDAV: begin
        txd_d = 1'b1;
        rfd_d = dav_;
      end
      START, DATA, PAR, STOP: begin
        rfd_d = 1'b0;
        if (tick_zero) begin
          unique case (state_d)
            DATA:    txd_d = buf_q[3'(4'd8 - bit_cnt_d)];
            PAR:     txd_d = par_q;
            default: txd_d = 1'b1;
          endcase
        end
      end
      default: begin
        txd_d = 1'b1;
        rfd_d = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_trasmettitore_seriale.sv
// Bench for trasmettitore_seriale: three instances (no, even, odd parity)
// share clock and reset; each frame is checked every clock against the bit
// sequence computed from the byte value and the parity rule.
module tb_trasmettitore_seriale;

  localparam int BT = 16;

  logic       clock = 1'b0;
  logic       reset;
  logic [2:0] dav_n;
  logic [2:0] rfd_w;
  logic [2:0] txd_w;
  logic [7:0] byte_in [3];

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  always #5 clock = ~clock;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    trasmettitore_seriale #(
      .BIT_TICKS(BT),
      .PARITY   (g)
    ) u_dut (
      .clock  (clock),
      .reset  (reset),
      .dav_   (dav_n[g]),
      .byte_in(byte_in[g]),
      .rfd    (rfd_w[g]),
      .txd    (txd_w[g])
    );
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Expected line level for frame bit idx of byte d on instance k (parity mode k)
  function automatic logic frame_bit(input int k, input logic [7:0] d, input int idx);
    int ones;
    ones = $countones(d);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return d[idx-1];
    if (idx == 9 && k == 1) return (ones % 2) == 1;
    if (idx == 9 && k == 2) return (ones % 2) == 0;
    return 1'b1;
  endfunction

  // Starts at the capture edge; dav_ must already be low.
  task automatic check_frame(input int k, input logic [7:0] d, input int hold,
                             input bit rnd, input logic [7:0] during);
    int nb;
    nb = (k == 0) ? 10 : 11;
    @(posedge clock);
    for (int n = 0; n < nb * BT; n++) begin
      #1;
      check_eq("txd_bit", 32'(txd_w[k]), 32'(frame_bit(k, d, n / BT)));
      check_eq("rfd_busy", 32'(rfd_w[k]), 32'd0);
      @(negedge clock);
      if (rnd) begin
        byte_in[k] = 8'($urandom);
        dav_n[k]   = 1'($urandom);
      end else begin
        byte_in[k] = during;
      end
      @(posedge clock);
    end
    #1;
    check_eq("wdav_txd", 32'(txd_w[k]), 32'd1);
    check_eq("wdav_rfd", 32'(rfd_w[k]), 32'd0);
    for (int h = 0; h < hold; h++) begin
      @(negedge clock);
      dav_n[k] = 1'b0;
      @(posedge clock);
      #1;
      check_eq("hold_txd", 32'(txd_w[k]), 32'd1);
      check_eq("hold_rfd", 32'(rfd_w[k]), 32'd0);
    end
    @(negedge clock);
    dav_n[k] = 1'b1;
    @(posedge clock);
    #1;
    check_eq("rel_rfd", 32'(rfd_w[k]), 32'd1);
    check_eq("rel_txd", 32'(txd_w[k]), 32'd1);
  endtask

  task automatic run_frame(input int k, input logic [7:0] d, input int hold,
                           input bit rnd, input logic [7:0] during);
    @(negedge clock);
    byte_in[k] = d;
    dav_n[k]   = 1'b0;
    check_frame(k, d, hold, rnd, during);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    dav_n = '1;
    for (int i = 0; i < 3; i++) byte_in[i] = '0;
    #12;
    for (int k = 0; k < 3; k++) begin
      check_eq("reset_txd", 32'(txd_w[k]), 32'd1);
      check_eq("reset_rfd", 32'(rfd_w[k]), 32'd1);
    end
    @(negedge clock);
    reset = 1'b0;

    // Directed frames
    run_frame(0, 8'hA5, 3, 1'b0, 8'hA5);
    run_frame(1, 8'h07, 0, 1'b0, 8'h07);
    run_frame(2, 8'h00, 1, 1'b0, 8'h00);
    run_frame(2, 8'hFF, 0, 1'b0, 8'hFF);
    run_frame(0, 8'h3C, 400, 1'b0, 8'h3C);
    run_frame(0, 8'h55, 0, 1'b0, 8'hAA);
    for (int k = 0; k < 3; k++) begin
      run_frame(k, 8'h00, 0, 1'b0, 8'h00);
      run_frame(k, 8'hFF, 0, 1'b0, 8'hFF);
      run_frame(k, 8'h5A, 0, 1'b0, 8'h5A);
    end

    // Random data, random mid-frame input disturbance, random release delay
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 6; i++) begin
        run_frame(k, 8'($urandom), int'($urandom_range(0, 4)), 1'b1, 8'h00);
      end
    end

    // Reset 50 clocks into a frame of 8'hFF
    @(negedge clock);
    byte_in[0] = 8'hFF;
    dav_n[0]   = 1'b0;
    @(posedge clock);
    repeat (50) @(posedge clock);
    @(negedge clock);
    #1;
    reset    = 1'b1;
    dav_n[0] = 1'b1;
    #1;
    check_eq("rst_async_txd", 32'(txd_w[0]), 32'd1);
    check_eq("rst_async_rfd", 32'(rfd_w[0]), 32'd1);
    @(posedge clock);
    #1;
    check_eq("rst_hold_txd", 32'(txd_w[0]), 32'd1);
    @(negedge clock);
    reset = 1'b0;
    for (int n = 0; n < 11 * BT; n++) begin
      @(posedge clock);
      #1;
      check_eq("post_rst_txd", 32'(txd_w[0]), 32'd1);
      check_eq("post_rst_rfd", 32'(rfd_w[0]), 32'd1);
    end

    // dav_ already low when reset releases: first edge is a capture
    @(negedge clock);
    reset      = 1'b1;
    byte_in[1] = 8'hC3;
    dav_n[1]   = 1'b0;
    #1;
    check_eq("rst_dav_rfd", 32'(rfd_w[1]), 32'd1);
    @(negedge clock);
    reset = 1'b0;
    check_frame(1, 8'hC3, 2, 1'b0, 8'hC3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
